dac_feeder: RTL and testbench
=============================

Name: dac_feeder

Overview:
- Upstream sample feeder for the first-order delta-sigma DAC modulator.
- Accepts RES-bit PCM samples over a valid/ready stream and buffers them in a small FIFO.
- Presents each sample to the modulator's dac_in for exactly OSR clock cycles, with conv asserted continuously while streaming.
- Detects and reports underflow; deasserting conv returns the modulator to its idle state.

Parameters:
- RES, 8, sample width; must match the modulator's RES.
- OSR, 256, clock cycles per sample (oversampling ratio); must be >= 2.
- AW, 4, FIFO address width; DEPTH = 2^AW entries.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  FIFO can accept a sample.
- s_data  in  RES  upstream sample.
- enable  in  1  request streaming to the modulator.
- clr_status  in  1  one-cycle pulse; clears underflow and urun_cnt.
- conv  out  1  modulator enable; drives the modulator's conv.
- dac_in  out  RES  current sample; drives the modulator's dac_in.
- sample_tick  out  1  one-cycle pulse on the cycle a new dac_in value first appears.
- level  out  AW+1  FIFO occupancy, 0..DEPTH.
- underflow  out  1  sticky underflow flag.
- urun_cnt  out  8  saturating underflow event count.

Behaviour:
- Reset: all clocked state clears on the rising clk edge while rst=1. This gives conv=0, dac_in=0, sample_tick=0, level=0, underflow=0, urun_cnt=0, state=IDLE and per_cnt=0. s_ready is 0 while rst=1.
- Push: accept when s_valid && s_ready. s_ready = !rst && (level != DEPTH).
  - s_ready depends only on full. A pop in the same cycle does not allow a push into a full FIFO.
  - Simultaneous push and pop when not full leaves level unchanged.
- Pointers: wrap modulo DEPTH; level is tracked explicitly so full and empty are unambiguous.
- State IDLE: conv=0, dac_in=0.
  - If enable && level != 0: pop the head into dac_in, set conv<=1, pulse sample_tick, set per_cnt<=0, go to RUN.
  - A sample pushed at cycle t into an empty FIFO with enable=1 gives conv=1 and dac_in valid at t+2.
- State RUN: per_cnt increments each cycle. At per_cnt == OSR-1, per_cnt<=0 and one of the following applies, in priority order:
  - enable=0: go to IDLE; conv<=0, dac_in<=0. Data remaining in the FIFO is kept.
  - level != 0: pop the head into dac_in and pulse sample_tick.
  - level == 0 (underflow): dac_in holds its previous value, conv stays 1, no sample_tick. underflow<=1; urun_cnt increments, saturating at 255.
- Enable deassert mid-period: the current period always completes. conv falls exactly at a period boundary, never mid-period.
- Enable reassert while in RUN: no effect.
- Status: clr_status clears underflow and urun_cnt.
  - If clr_status coincides with an underflow event, the event wins: underflow=1, urun_cnt=1.
- Reset mid-RUN: conv=0 and dac_in=0 from the cycle after the rst edge; FIFO contents are discarded.
- Timing: all outputs are registered except s_ready and level, which are direct register-derived.

Decomposition:
- Shared package dac_pkg holds:
  - the feeder state enum (IDLE, RUN);
  - the RES and OSR default constants, shared with the modulator;
  - the urun_cnt width constant.
- Sub-module dac_fifo: synchronous single-clock FIFO parameterised by RES and AW.
  - Push/pop ports, level output.
  - Read is registered on pop.
- dac_feeder instantiates dac_fifo and contains the period counter and state machine.

Test Plan (bench: RES=8, OSR=4, AW=2 so DEPTH=4):
1. Reset: rst=1 for 2 cycles -> conv=0, dac_in=0x00, s_ready=0, level=0, underflow=0. After release, s_ready=1.
2. Streaming: enable=1, push 0x10, 0x80, 0xF0 on consecutive cycles.
   - conv rises 2 cycles after the first push.
   - dac_in=0x10 for 4 cycles, then 0x80 for 4, then 0xF0 for 4.
   - sample_tick pulses every 4 cycles, 3 times.
3. Underflow: continue test 2 with no pushes.
   - dac_in holds 0xF0; underflow=1 and urun_cnt=1 at the first empty boundary, urun_cnt=2 at the next.
   - Push 0x33 -> dac_in=0x33 at the following boundary; underflow stays 1.
   - clr_status pulse -> underflow=0, urun_cnt=0.
4. Full: enable=0, s_valid held high with 5 samples.
   - 4 accepted, level=4, s_ready=0.
   - Assert enable -> first pop; 5th sample accepted the cycle after level drops to 3.
5. Enable drop: with RUN active, deassert enable at per_cnt=1.
   - conv stays 1 through per_cnt=3, then conv=0 and dac_in=0x00.
   - level is unchanged by the drop.
6. Reset mid-RUN: assert rst with level=2 during RUN -> next cycle conv=0, level=0, state IDLE. After release with enable=1, no conv until a new push.

Source files
------------

// File: rtl/dac_pkg.sv
// Constants and types shared by the delta-sigma DAC feeder, its FIFO and the modulator.
package dac_pkg;

    localparam int DAC_RES = 8;
    localparam int DAC_OSR = 256;
    localparam int URUN_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/dac_fifo.sv
// Single-clock sample FIFO with an explicit occupancy count and a read register
// that loads the head on pop and can be cleared back to zero.
module dac_fifo
    import dac_pkg::*;
#(
    parameter int RES = DAC_RES,
    parameter int AW  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push_i,
    input  logic [RES-1:0] push_data_i,
    input  logic           pop_i,
    input  logic           rd_clr_i,
    output logic           full_o,
    output logic [AW:0]    level_o,
    output logic [RES-1:0] rd_data_o
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

    logic [RES-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [AW:0]    level_q;
    logic [RES-1:0] rd_data_q;
    logic           push_ok;
    logic           pop_ok;

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign full_o    = (level_q == LEVEL_FULL);
    assign push_ok   = push_i && !full_o;
    assign pop_ok    = pop_i && (level_q != '0);
    assign level_o   = level_q;
    assign rd_data_o = rd_data_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
            if (rd_clr_i) begin
                rd_data_q <= '0;
            end else if (pop_ok) begin
                rd_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

endmodule

// File: rtl/dac_feeder.sv
// Feeds buffered PCM samples to the delta-sigma modulator, holding each one for
// OSR cycles and flagging underflow when the FIFO runs dry at a period boundary.
module dac_feeder
    import dac_pkg::*;
#(
    parameter int RES = DAC_RES,
    parameter int OSR = DAC_OSR,
    parameter int AW  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [RES-1:0]    s_data,
    input  logic              enable,
    input  logic              clr_status,
    output logic              conv,
    output logic [RES-1:0]    dac_in,
    output logic              sample_tick,
    output logic [AW:0]       level,
    output logic              underflow,
    output logic [URUN_W-1:0] urun_cnt
);

    localparam int PCW = (OSR > 2) ? $clog2(OSR) : 1;
    localparam logic [PCW-1:0] PER_LAST = PCW'(OSR - 1);

    feeder_state_t     state_q;
    logic [PCW-1:0]    per_cnt_q;
    logic              conv_q;
    logic              tick_q;
    logic              underflow_q;
    logic [URUN_W-1:0] urun_q;
    logic [URUN_W-1:0] urun_base;
    logic [URUN_W-1:0] urun_d;

    logic              fifo_full;
    logic              boundary;
    logic              pop;
    logic              rd_clr;

    assign s_ready     = !rst && !fifo_full;
    assign conv        = conv_q;
    assign sample_tick = tick_q;
    assign underflow   = underflow_q;
    assign urun_cnt    = urun_q;

    dac_fifo #(
        .RES (RES),
        .AW  (AW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (s_valid && s_ready),
        .push_data_i (s_data),
        .pop_i       (pop),
        .rd_clr_i    (rd_clr),
        .full_o      (fifo_full),
        .level_o     (level),
        .rd_data_o   (dac_in)
    );

    // Pop and clear decisions must reach the FIFO in the same cycle the FSM moves.
    always_comb begin
        pop      = 1'b0;
        rd_clr   = 1'b0;
        boundary = (state_q == RUN) && (per_cnt_q == PER_LAST);
        if (state_q == IDLE) begin
            pop = enable && (level != '0);
        end else if (boundary) begin
            if (!enable) begin
                rd_clr = 1'b1;
            end else if (level != '0) begin
                pop = 1'b1;
            end
        end
    end

    // A clear arriving with an underflow event restarts the count from that event.
    always_comb begin
        urun_base = clr_status ? '0 : urun_q;
        urun_d    = (urun_base == '1) ? urun_base : urun_base + URUN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            per_cnt_q   <= '0;
            conv_q      <= 1'b0;
            tick_q      <= 1'b0;
            underflow_q <= 1'b0;
            urun_q      <= '0;
        end else begin
            tick_q <= 1'b0;
            if (clr_status) begin
                underflow_q <= 1'b0;
                urun_q      <= '0;
            end
            case (state_q)
                IDLE: begin
                    conv_q    <= 1'b0;
                    per_cnt_q <= '0;
                    if (pop) begin
                        conv_q  <= 1'b1;
                        tick_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (boundary) begin
                        per_cnt_q <= '0;
                        if (!enable) begin
                            conv_q  <= 1'b0;
                            state_q <= IDLE;
                        end else if (level != '0) begin
                            tick_q <= 1'b1;
                        end else begin
                            underflow_q <= 1'b1;
                            urun_q      <= urun_d;
                        end
                    end else begin
                        per_cnt_q <= per_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    conv_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_feeder.sv
// Directed bench for dac_feeder with OSR=4 and a 4-entry FIFO; expected values
// are hand-derived cycle by cycle from the feeder's streaming rules.
module tb_dac_feeder;

    logic       clk;
    logic       rst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       enable;
    logic       clr_status;
    logic       conv;
    logic [7:0] dac_in;
    logic       sample_tick;
    logic [2:0] level;
    logic       underflow;
    logic [7:0] urun_cnt;

    int nCompared   = 0;
    int nMismatched = 0;

    dac_feeder #(
        .RES (8),
        .OSR (4),
        .AW  (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .enable      (enable),
        .clr_status  (clr_status),
        .conv        (conv),
        .dac_in      (dac_in),
        .sample_tick (sample_tick),
        .level       (level),
        .underflow   (underflow),
        .urun_cnt    (urun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic applyStimulus(input logic v, input logic [7:0] d,
                                 input logic en, input logic clr);
        s_valid    = v;
        s_data     = d;
        enable     = en;
        clr_status = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst        = 1'b1;
        s_valid    = 1'b0;
        s_data     = 8'h00;
        enable     = 1'b0;
        clr_status = 1'b0;

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("rst_conv", 32'(conv), 32'd0);
        checkOutput("rst_dac", 32'(dac_in), 32'h00);
        checkOutput("rst_ready", 32'(s_ready), 32'd0);
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_uflow", 32'(underflow), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rel_ready", 32'(s_ready), 32'd1);

        applyStimulus(1'b1, 8'h10, 1'b1, 1'b0);
        checkOutput("p1_conv", 32'(conv), 32'd0);
        checkOutput("p1_level", 32'(level), 32'd1);
        applyStimulus(1'b1, 8'h80, 1'b1, 1'b0);
        checkOutput("p2_conv", 32'(conv), 32'd1);
        for (int k = 0; k < 12; k++) begin
            logic [7:0] expDac;
            expDac = (k < 4) ? 8'h10 : (k < 8) ? 8'h80 : 8'hF0;
            checkOutput($sformatf("stream_dac_%0d", k), 32'(dac_in), 32'(expDac));
            checkOutput($sformatf("stream_tick_%0d", k), 32'(sample_tick),
                        32'((k % 4) == 0));
            checkOutput($sformatf("stream_conv_%0d", k), 32'(conv), 32'd1);
            if (k == 0) applyStimulus(1'b1, 8'hF0, 1'b1, 1'b0);
            else        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        end

        checkOutput("uf1_flag", 32'(underflow), 32'd1);
        checkOutput("uf1_cnt", 32'(urun_cnt), 32'd1);
        checkOutput("uf1_dac", 32'(dac_in), 32'hF0);
        checkOutput("uf1_tick", 32'(sample_tick), 32'd0);
        checkOutput("uf1_conv", 32'(conv), 32'd1);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("uf1_cnt_hold", 32'(urun_cnt), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("uf2_cnt", 32'(urun_cnt), 32'd2);
        checkOutput("uf2_dac", 32'(dac_in), 32'hF0);
        applyStimulus(1'b1, 8'h33, 1'b1, 1'b0);
        checkOutput("push33_level", 32'(level), 32'd1);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("s33_dac", 32'(dac_in), 32'h33);
        checkOutput("s33_tick", 32'(sample_tick), 32'd1);
        checkOutput("s33_uflow", 32'(underflow), 32'd1);
        checkOutput("s33_cnt", 32'(urun_cnt), 32'd2);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("clr_uflow", 32'(underflow), 32'd0);
        checkOutput("clr_cnt", 32'(urun_cnt), 32'd0);

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("drop0_conv", 32'(conv), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("drop0_conv_b", 32'(conv), 32'd1);
        checkOutput("drop0_dac_b", 32'(dac_in), 32'h33);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("drop0_conv_off", 32'(conv), 32'd0);
        checkOutput("drop0_dac_off", 32'(dac_in), 32'h00);

        applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hA4, 1'b0, 1'b0);
        checkOutput("full_level", 32'(level), 32'd4);
        checkOutput("full_ready", 32'(s_ready), 32'd0);
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
        checkOutput("full_blocked", 32'(level), 32'd4);
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
        checkOutput("full_pop_level", 32'(level), 32'd3);
        checkOutput("full_pop_ready", 32'(s_ready), 32'd1);
        checkOutput("full_pop_conv", 32'(conv), 32'd1);
        checkOutput("full_pop_dac", 32'(dac_in), 32'hA1);
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
        checkOutput("fifth_level", 32'(level), 32'd4);

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("drop_conv_2", 32'(conv), 32'd1);
        checkOutput("drop_dac_2", 32'(dac_in), 32'hA1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("drop_conv_3", 32'(conv), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("drop_conv_off", 32'(conv), 32'd0);
        checkOutput("drop_dac_off", 32'(dac_in), 32'h00);
        checkOutput("drop_level", 32'(level), 32'd4);
        checkOutput("drop_tick", 32'(sample_tick), 32'd0);

        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("rerun_dac", 32'(dac_in), 32'hA2);
        checkOutput("rerun_level", 32'(level), 32'd3);
        repeat (4) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("rerun_dac_a3", 32'(dac_in), 32'hA3);
        checkOutput("rerun_level_2", 32'(level), 32'd2);
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("midrst_conv", 32'(conv), 32'd0);
        checkOutput("midrst_level", 32'(level), 32'd0);
        checkOutput("midrst_dac", 32'(dac_in), 32'h00);
        checkOutput("midrst_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("postrst_conv", 32'(conv), 32'd0);
        checkOutput("postrst_level", 32'(level), 32'd0);
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0);
        checkOutput("postrst_push_level", 32'(level), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("postrst_conv_on", 32'(conv), 32'd1);
        checkOutput("postrst_dac", 32'(dac_in), 32'h5A);
        checkOutput("postrst_tick", 32'(sample_tick), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
